and_gate_core: RTL and testbench
================================

Name: and_gate_core

Overview:
- Parameterised bitwise two-input AND block.
- Provides an immediate combinational result `y = a & b`, plus a registered copy with a valid flag.
- Registered reduction flags and a saturating count of all-ones results.
- Leaf cell used wherever gated logic needs both a zero-latency path and a clean registered path.

Parameters:
- WIDTH, 1, bit width of operands a, b and results y, y_q.
- CNT_W, 16, width of the all-ones event counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- in_valid  input  1  qualifies a/b for the registered path
- clr  input  1  synchronous clear of the event counter
- y  output  WIDTH  combinational a & b
- y_q  output  WIDTH  registered a & b
- out_valid  output  1  y_q holds a newly captured result this cycle
- all_ones  output  1  registered reduction-AND of captured result
- any_one  output  1  registered reduction-OR of captured result
- ones_cnt  output  CNT_W  saturating count of captured all-ones results

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. All registers take reset values immediately when rst_n falls. Release is synchronous to the next clk rising edge.
- Reset values: y_q=0, out_valid=0, all_ones=0, any_one=0, ones_cnt=0. y is unaffected by reset.
- Combinational path y:
  - y = a & b bitwise, zero latency.
  - Purely combinational: no clock or reset dependency, no glitch filtering.
  - Any change on a or b propagates to y in the same delta/time step.
- Registered path, latency 1 cycle:
  - If in_valid=1 at the clk edge: y_q <= a & b, all_ones <= &(a & b), any_one <= |(a & b), out_valid <= 1.
  - If in_valid=0: y_q, all_ones and any_one hold their values, and out_valid <= 0.
  - out_valid pulses for exactly one cycle per accepted input; back-to-back in_valid gives continuous out_valid.
- Counter ones_cnt:
  - Increments by 1 on a clk edge where in_valid=1 and &(a & b)=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr=1 forces ones_cnt to 0 at the edge; clr has priority over a simultaneous increment.
  - clr does not affect y_q, out_valid or the flags.
- Reset mid-operation: any pending capture is discarded. out_valid=0 on the first cycle after release, even if in_valid was high during reset.
- WIDTH=1: all_ones = any_one = y_q.

Optional Feature:
- Macro: AND_GATE_NAND_EN.
- Defined: adds output port y_n (WIDTH), combinational ~(a & b), zero latency, independent of clk/rst_n. Also adds output y_n_q (WIDTH), registered ~(a & b) captured under the same in_valid rule, reset value all ones.
- Not defined: ports y_n and y_n_q are absent; no other behaviour changes.

Test Plan:
- WIDTH=1 truth table via toggling: a starts 0 and toggles every 2 time units, b starts 0 and toggles every 3. Expected y: t0 (0,0)->0, t2 (1,0)->0, t3 (1,1)->1, t4 (0,1)->0, t6 (1,0)->0, t8 (0,0)->0, t9 (0,1)->0. y follows with zero delay; run ends at t10.
- WIDTH=8, a=8'hF0, b=8'h3C, in_valid=1 for one cycle -> y=8'h30 immediately. Next edge: y_q=8'h30, out_valid=1, any_one=1, all_ones=0. Following cycle with in_valid=0 -> out_valid=0, y_q holds 8'h30.
- WIDTH=8, a=b=8'hFF with in_valid=1 for 5 cycles -> ones_cnt=5, all_ones=1. Assert clr together with a sixth valid all-ones input -> ones_cnt=0.
- CNT_W=2, 5 consecutive all-ones captures -> ones_cnt reaches 3 and stays 3.
- rst_n low mid-stream with in_valid=1 and a=b=all ones -> outputs go to reset values immediately (asynchronously). First edge after release gives out_valid=0; capture resumes on the second edge.
- With AND_GATE_NAND_EN defined: a=8'hAA, b=8'h0F -> y_n=8'hF5. After reset, y_n_q=8'hFF.

Source files
------------

// File: rtl/and_gate_core.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// and_gate_core
//   Parameterised bitwise two-input AND leaf cell. Offers a zero-latency
//   combinational result alongside a registered copy with a one-cycle valid
//   pulse, registered reduction flags and a saturating count of captured
//   all-ones results.
//
// Parameters
//   WIDTH     operand / result width
//   CNT_W     width of the all-ones event counter
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   a, b       in   operands (WIDTH)
//   in_valid   in   qualifies a/b for the registered path
//   clr        in   synchronous clear of ones_cnt (wins over an increment)
//   y          out  combinational a & b
//   y_q        out  registered a & b
//   out_valid  out  y_q holds a result captured on the last edge
//   all_ones   out  registered reduction-AND of the captured result
//   any_one    out  registered reduction-OR of the captured result
//   ones_cnt   out  saturating count of captured all-ones results (CNT_W)
//
// Optional feature, enabled by defining AND_GATE_NAND_EN
//   y_n        out  combinational ~(a & b)
//   y_n_q      out  registered ~(a & b), same capture rule, resets to all ones
// -----------------------------------------------------------------------------
module and_gate_core #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             all_ones,
  output logic             any_one,
  output logic [CNT_W-1:0] ones_cnt
`ifdef AND_GATE_NAND_EN
  ,
  output logic [WIDTH-1:0] y_n,
  output logic [WIDTH-1:0] y_n_q
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Shared bitwise product feeding both the live and the registered paths
  logic [WIDTH-1:0] and_c;
  assign and_c = a & b;
  assign y     = and_c;

`ifdef AND_GATE_NAND_EN
  assign y_n = ~and_c;
`endif

  // live_q stays low through the first edge after reset release so that a
  // request held high across reset is discarded rather than captured.
  logic             live_q,   live_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic             valid_q,  valid_d;
  logic             all_q,    all_d;
  logic             any_q,    any_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
`ifdef AND_GATE_NAND_EN
  logic [WIDTH-1:0] ndata_q,  ndata_d;
`endif

  logic capture_c;
  logic hit_c;
  assign capture_c = in_valid & live_q;
  assign hit_c     = capture_c & (&and_c);

  // Next-state logic for the registered path and the event counter
  always_comb begin
    live_d  = 1'b1;
    data_d  = data_q;
    valid_d = capture_c;
    all_d   = all_q;
    any_d   = any_q;
    cnt_d   = cnt_q;
`ifdef AND_GATE_NAND_EN
    ndata_d = ndata_q;
`endif

    if (capture_c) begin
      data_d = and_c;
      all_d  = &and_c;
      any_d  = |and_c;
`ifdef AND_GATE_NAND_EN
      ndata_d = ~and_c;
`endif
    end

    // Clear has priority; increment stops at the top value instead of wrapping
    if (clr) begin
      cnt_d = '0;
    end else if (hit_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      all_q   <= 1'b0;
      any_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef AND_GATE_NAND_EN
      ndata_q <= '1;
`endif
    end else begin
      live_q  <= live_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      all_q   <= all_d;
      any_q   <= any_d;
      cnt_q   <= cnt_d;
`ifdef AND_GATE_NAND_EN
      ndata_q <= ndata_d;
`endif
    end
  end

  assign y_q       = data_q;
  assign out_valid = valid_q;
  assign all_ones  = all_q;
  assign any_one   = any_q;
  assign ones_cnt  = cnt_q;
`ifdef AND_GATE_NAND_EN
  assign y_n_q     = ndata_q;
`endif

endmodule

// File: tb/tb_and_gate_core.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_and_gate_core
//   Two instances: an 8-bit cell with a 16-bit counter and a 1-bit cell with a
//   2-bit counter (for saturation). Directed steps followed by random steps,
//   each compared against a behavioural model of the cell's rules.
// -----------------------------------------------------------------------------
module tb_and_gate_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-bit instance
  logic [7:0]  a8, b8, y8, yq8;
  logic        v8, c8, ov8, all8, any8;
  logic [15:0] cnt8;
  // 1-bit instance
  logic        a1, b1, y1, yq1;
  logic        v1, c1, ov1, all1, any1;
  logic [1:0]  cnt1;
`ifdef AND_GATE_NAND_EN
  logic [7:0]  yn8, ynq8;
  logic        yn1, ynq1;
`endif

  and_gate_core #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8), .clr(c8),
    .y(y8), .y_q(yq8), .out_valid(ov8), .all_ones(all8), .any_one(any8),
    .ones_cnt(cnt8)
`ifdef AND_GATE_NAND_EN
    , .y_n(yn8), .y_n_q(ynq8)
`endif
  );

  and_gate_core #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .clr(c1),
    .y(y1), .y_q(yq1), .out_valid(ov1), .all_ones(all1), .any_one(any1),
    .ones_cnt(cnt1)
`ifdef AND_GATE_NAND_EN
    , .y_n(yn1), .y_n_q(ynq1)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Behavioural model: expected registered state after each clock edge
  logic        m_live;
  logic [7:0]  m8_yq, m8_nq;
  logic        m8_ov, m8_all, m8_any;
  int          m8_cnt;
  logic        m1_yq, m1_nq, m1_ov;
  int          m1_cnt;

  task automatic model_reset();
    m_live = 1'b0;
    m8_yq = 8'h00; m8_nq = 8'hFF; m8_ov = 1'b0; m8_all = 1'b0; m8_any = 1'b0; m8_cnt = 0;
    m1_yq = 1'b0;  m1_nq = 1'b1;  m1_ov = 1'b0; m1_cnt = 0;
  endtask

  task automatic model_edge();
    logic [7:0] p8;
    logic       p1;
    p8 = a8 & b8;
    p1 = a1 & b1;
    if (!m_live) begin
      // first edge after release: nothing is captured
      m_live = 1'b1;
      m8_ov  = 1'b0;
      m1_ov  = 1'b0;
    end else begin
      m8_ov = v8;
      if (v8) begin
        m8_yq = p8; m8_nq = ~p8; m8_all = (p8 == 8'hFF); m8_any = (p8 != 8'h00);
      end
      if (c8) m8_cnt = 0;
      else if (v8 && p8 == 8'hFF) m8_cnt = (m8_cnt < 65535) ? m8_cnt + 1 : 65535;
      m1_ov = v1;
      if (v1) begin
        m1_yq = p1; m1_nq = ~p1;
      end
      if (c1) m1_cnt = 0;
      else if (v1 && p1) m1_cnt = (m1_cnt < 3) ? m1_cnt + 1 : 3;
    end
  endtask

  task automatic check_regs(input string phase);
    check({phase, ".y_q8"},      32'(yq8),  32'(m8_yq));
    check({phase, ".valid8"},    32'(ov8),  32'(m8_ov));
    check({phase, ".all8"},      32'(all8), 32'(m8_all));
    check({phase, ".any8"},      32'(any8), 32'(m8_any));
    check({phase, ".cnt8"},      32'(cnt8), 32'(m8_cnt));
    check({phase, ".y_q1"},      32'(yq1),  32'(m1_yq));
    check({phase, ".valid1"},    32'(ov1),  32'(m1_ov));
    check({phase, ".all1"},      32'(all1), 32'(m1_yq));
    check({phase, ".any1"},      32'(any1), 32'(m1_yq));
    check({phase, ".cnt1"},      32'(cnt1), 32'(m1_cnt));
`ifdef AND_GATE_NAND_EN
    check({phase, ".y_n_q8"},    32'(ynq8), 32'(m8_nq));
    check({phase, ".y_n_q1"},    32'(ynq1), 32'(m1_nq));
`endif
  endtask

  task automatic check_comb(input string phase);
    check({phase, ".y8"}, 32'(y8), 32'(a8 & b8));
    check({phase, ".y1"}, 32'(y1), 32'(a1 & b1));
`ifdef AND_GATE_NAND_EN
    check({phase, ".y_n8"}, 32'(yn8), 32'(~(a8 & b8)));
    check({phase, ".y_n1"}, 32'(yn1), 32'(~(a1 & b1)));
`endif
  endtask

  // One clocked step: drive, check live path, clock, check registered path
  task automatic step(input string phase,
                      input logic [7:0] a8v, input logic [7:0] b8v, input logic v8v, input logic c8v,
                      input logic a1v, input logic b1v, input logic v1v, input logic c1v);
    a8 = a8v; b8 = b8v; v8 = v8v; c8 = c8v;
    a1 = a1v; b1 = b1v; v1 = v1v; c1 = c1v;
    #1;
    check_comb(phase);
    @(posedge clk);
    model_edge();
    #1;
    check_regs(phase);
  endtask

  initial begin
    rst_n = 1'b0;
    a8 = '0; b8 = '0; v8 = 1'b0; c8 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; c1 = 1'b0;
    model_reset();

    // 1-bit truth table: a toggles every 2 units, b every 3; y checked mid-unit
    for (int t = 0; t < 10; t++) begin
      a1 = ((t / 2) % 2) == 1;
      b1 = ((t / 3) % 2) == 1;
      #0.5;
      check($sformatf("tt.t%0d", t), 32'(y1), 32'(((t / 2) % 2) & ((t / 3) % 2)));
      #0.5;
    end
    a1 = 1'b0; b1 = 1'b0;
    #1;

    check_regs("reset");

    @(negedge clk);
    rst_n = 1'b1;

    // release edge, then the F0/3C capture and a hold cycle
    step("rel",  8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("f03c", 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("f03c.y_q_lit", 32'(yq8), 32'h30);
    step("hold", 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hold.y_q_lit", 32'(yq8), 32'h30);

    // five all-ones captures, then clear racing a sixth
    for (int i = 0; i < 5; i++)
      step("ones", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("ones.cnt8_lit", 32'(cnt8), 32'd5);
    check("ones.cnt1_sat", 32'(cnt1), 32'd3);
    step("clr",  8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("clr.cnt8_lit", 32'(cnt8), 32'd0);
    check("clr.all8_lit", 32'(all8), 32'd1);

    // random traffic, biased toward all-ones so the counters move
    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra, rb;
      logic       r1a, r1b;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if ($urandom_range(3) == 0) begin ra = 8'hFF; rb = 8'hFF; end
      r1a = ($urandom_range(3) != 0);
      r1b = ($urandom_range(3) != 0);
      step("rand", ra, rb, 1'($urandom), ($urandom_range(15) == 0),
           r1a, r1b, 1'($urandom), ($urandom_range(15) == 0));
    end

    // asynchronous reset in the middle of a cycle with valid all-ones traffic
    a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1; c8 = 1'b0;
    a1 = 1'b1;  b1 = 1'b1;  v1 = 1'b1; c1 = 1'b0;
    @(posedge clk);
    model_edge();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("arst");
    check_comb("arst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("rel2", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("rel2.valid_lit", 32'(ov8), 32'd0);
    step("cap2", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("cap2.valid_lit", 32'(ov8), 32'd1);
    check("cap2.cnt_lit",   32'(cnt8), 32'd1);

`ifdef AND_GATE_NAND_EN
    a8 = 8'hAA; b8 = 8'h0F;
    #1;
    check("nand.y_n_lit", 32'(yn8), 32'hF5);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
